// File: rtl/wall_scan_reader_if.sv
// Request/result bundle between the wall scan reader and its client.
// The client drives the master side; the reader is the slave.
interface wall_scan_reader_if #(
  parameter int NUM_WALLS = 25,
  parameter int IDX_W     = 5
);
  logic                       start;
  logic [3:0]                 query_x;
  logic [3:0]                 query_y;
  logic [NUM_WALLS-1:0][7:0]  wall_locations;
  logic [3:0]                 xmax;
  logic [3:0]                 xmin;
  logic [3:0]                 ymax;
  logic [3:0]                 ymin;
  logic                       busy;
  logic                       done;
  logic                       hit;
  logic                       hit_border;
  logic [IDX_W-1:0]           hit_index;

  modport master (
    output start,
    output query_x,
    output query_y,
    output wall_locations,
    output xmax,
    output xmin,
    output ymax,
    output ymin,
    input  busy,
    input  done,
    input  hit,
    input  hit_border,
    input  hit_index
  );

  modport slave (
    input  start,
    input  query_x,
    input  query_y,
    input  wall_locations,
    input  xmax,
    input  xmin,
    input  ymax,
    input  ymin,
    output busy,
    output done,
    output hit,
    output hit_border,
    output hit_index
  );
endinterface

// File: rtl/wall_scan_reader.sv
// Time-multiplexed wall hit test: snapshots the wall list, walks one entry per clock.
// Optional arena border check enabled by defining WALL_SCAN_BORDER_EN.
module wall_scan_reader #(
  parameter int NUM_WALLS = 25,
  parameter int IDX_W     = 5
) (
  input  logic             system_clk,
  input  logic             nrst,
  wall_scan_reader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_WALLS - 1);
  localparam logic [IDX_W-1:0] ONES = '1;

  state_t                    r_state;
  state_t                    w_next;
  logic [IDX_W-1:0]          r_idx;
  logic [3:0]                r_qx;
  logic [3:0]                r_qy;
  logic [NUM_WALLS-1:0][7:0] r_snap;
  logic                      r_hit;
  logic [IDX_W-1:0]          r_hit_index;

  logic [7:0]                w_entry;
  logic                      w_match;
  logic                      w_last;
  logic                      w_border;
  logic                      w_accept;
  logic                      w_hit_ent;
  logic                      w_hit_bdr;
  logic                      w_inc;

  assign w_entry = r_snap[r_idx];
  // 8'h00 marks an unused slot; (0,0) is never a list wall.
  assign w_match = (w_entry != 8'h00) &&
                   (w_entry == {r_qx, r_qy});
  assign w_last  = (r_idx == LAST);

  always_ff @(posedge system_clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_hit_ent = 1'b0;
    w_hit_bdr = 1'b0;
    w_inc     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept = 1'b1;
          w_next   = S_SCAN;
        end
      end
      S_SCAN: begin
        if (w_border) begin
          w_hit_bdr = 1'b1;
          w_next    = S_DONE;
        end else if (w_match) begin
          w_hit_ent = 1'b1;
          w_next    = S_DONE;
        end else if (w_last) begin
          w_next = S_DONE;
        end else begin
          w_inc = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge system_clk or negedge nrst) begin
    if (!nrst) begin
      r_idx  <= '0;
      r_qx   <= '0;
      r_qy   <= '0;
      r_snap <= '0;
    end else if (w_accept) begin
      r_idx  <= '0;
      r_qx   <= bus.query_x;
      r_qy   <= bus.query_y;
      r_snap <= bus.wall_locations;
    end else if (w_inc) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Results persist from DONE until the next accepted request.
  always_ff @(posedge system_clk or negedge nrst) begin
    if (!nrst) begin
      r_hit       <= 1'b0;
      r_hit_index <= ONES;
    end else if (w_accept) begin
      r_hit       <= 1'b0;
      r_hit_index <= ONES;
    end else if (w_hit_ent) begin
      r_hit       <= 1'b1;
      r_hit_index <= r_idx;
    end else if (w_hit_bdr) begin
      r_hit       <= 1'b1;
      r_hit_index <= ONES;
    end
  end

`ifdef WALL_SCAN_BORDER_EN
  logic [3:0] r_xmax;
  logic [3:0] r_xmin;
  logic [3:0] r_ymax;
  logic [3:0] r_ymin;
  logic       r_hit_border;

  always_ff @(posedge system_clk or negedge nrst) begin
    if (!nrst) begin
      r_xmax <= '0;
      r_xmin <= '0;
      r_ymax <= '0;
      r_ymin <= '0;
    end else if (w_accept) begin
      r_xmax <= bus.xmax;
      r_xmin <= bus.xmin;
      r_ymax <= bus.ymax;
      r_ymin <= bus.ymin;
    end
  end

  // Border is judged once, in the first scan cycle, ahead of entry 0.
  assign w_border = (r_idx == '0) &&
                    ((r_qx >= r_xmax) ||
                     (r_qy >= r_ymax) ||
                     (r_qx <= r_xmin) ||
                     (r_qy <= r_ymin));

  always_ff @(posedge system_clk or negedge nrst) begin
    if (!nrst) begin
      r_hit_border <= 1'b0;
    end else if (w_accept) begin
      r_hit_border <= 1'b0;
    end else if (w_hit_bdr) begin
      r_hit_border <= 1'b1;
    end
  end

  assign bus.hit_border = r_hit_border;
`else
  assign w_border       = 1'b0;
  assign bus.hit_border = 1'b0;
`endif

  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_DONE);
  assign bus.hit       = r_hit;
  assign bus.hit_index = r_hit_index;

endmodule

// File: tb/tb_wall_scan_reader.sv
// Directed and randomized checks of wall_scan_reader against a list-search model.
// Honours WALL_SCAN_BORDER_EN in the reference model.
module tb_wall_scan_reader;

  localparam int NW = 25;
  localparam int IW = 5;
  localparam logic [IW-1:0] ONES = '1;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  wall_scan_reader_if #(.NUM_WALLS(NW), .IDX_W(IW)) ifc ();

  wall_scan_reader #(
    .NUM_WALLS(NW),
    .IDX_W    (IW)
  ) dut (
    .system_clk(clk),
    .nrst      (nrst),
    .bus       (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: first non-empty matching entry; border takes precedence.
  task automatic model(input logic [3:0] qx, input logic [3:0] qy,
                       input logic [NW-1:0][7:0] w,
                       input logic [3:0] xmx, input logic [3:0] xmn,
                       input logic [3:0] ymx, input logic [3:0] ymn,
                       output logic e_hit, output logic e_bdr,
                       output logic [IW-1:0] e_idx, output int e_lat);
    e_hit = 1'b0;
    e_bdr = 1'b0;
    e_idx = ONES;
    e_lat = NW + 1;
`ifdef WALL_SCAN_BORDER_EN
    if (qx >= xmx || qy >= ymx || qx <= xmn || qy <= ymn) begin
      e_hit = 1'b1;
      e_bdr = 1'b1;
      e_lat = 2;
      return;
    end
`else
    if (xmx == xmn && ymx == ymn && xmx != xmn) e_lat = 0;
`endif
    for (int i = 0; i < NW; i++) begin
      if (w[i] != 8'h00 && w[i] == {qx, qy}) begin
        e_hit = 1'b1;
        e_idx = IW'(i);
        e_lat = i + 2;
        return;
      end
    end
  endtask

  task automatic run_scan(input string tag, input logic [3:0] qx,
                          input logic [3:0] qy,
                          input logic [NW-1:0][7:0] w,
                          input int ign_cyc, input bit mutate);
    logic          e_hit;
    logic          e_bdr;
    logic [IW-1:0] e_idx;
    int            e_lat;
    int            cyc;
    bit            got;
    model(qx, qy, w, ifc.xmax, ifc.xmin, ifc.ymax, ifc.ymin,
          e_hit, e_bdr, e_idx, e_lat);
    @(negedge clk);
    ifc.query_x        = qx;
    ifc.query_y        = qy;
    ifc.wall_locations = w;
    ifc.start          = 1'b1;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      ifc.start = (cyc == ign_cyc);
      if (mutate) begin
        ifc.query_x           = ~qx;
        ifc.wall_locations[10] = 8'($urandom);
        ifc.wall_locations[0]  = {qx, qy};
      end
      if (cyc == 1) check({tag, " busy"}, ifc.busy, 1'b1);
      if (ifc.done) got = 1'b1;
    end
    ifc.start = 1'b0;
    check({tag, " done_seen"}, got, 1'b1);
    check({tag, " latency"}, cyc, e_lat);
    check({tag, " hit"}, ifc.hit, e_hit);
    check({tag, " hit_index"}, ifc.hit_index, e_idx);
    check({tag, " hit_border"}, ifc.hit_border, e_bdr);
    @(posedge clk);
    @(negedge clk);
    check({tag, " done_drop"}, ifc.done, 1'b0);
    check({tag, " busy_drop"}, ifc.busy, 1'b0);
    check({tag, " hold"}, {ifc.hit, ifc.hit_index}, {e_hit, e_idx});
  endtask

  logic [NW-1:0][7:0] w;
  logic [3:0]         rq_x;
  logic [3:0]         rq_y;
  int                 seen;

  initial begin
    checks = 0;
    errors = 0;
    nrst   = 1'b0;
    ifc.start          = 1'b0;
    ifc.query_x        = '0;
    ifc.query_y        = '0;
    ifc.wall_locations = '0;
    ifc.xmin = 4'd0;
    ifc.xmax = 4'd15;
    ifc.ymin = 4'd0;
    ifc.ymax = 4'd15;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", ifc.busy, 1'b0);
    check("rst done", ifc.done, 1'b0);
    check("rst hit", ifc.hit, 1'b0);
    check("rst border", ifc.hit_border, 1'b0);
    check("rst index", ifc.hit_index, ONES);
    @(negedge clk);
    nrst = 1'b1;

    // Reset mid-scan
    @(negedge clk);
    ifc.query_x        = 4'd4;
    ifc.query_y        = 4'd4;
    ifc.wall_locations = '0;
    ifc.start          = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (9) @(negedge clk);
    nrst = 1'b0;
    #1;
    check("mid busy", ifc.busy, 1'b0);
    check("mid done", ifc.done, 1'b0);
    check("mid hit", ifc.hit, 1'b0);
    check("mid index", ifc.hit_index, ONES);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (ifc.done) seen++;
    end
    nrst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (ifc.done) seen++;
    end
    check("mid no_done", seen, 0);

    // Entry hit at index 7
    w = '0;
    w[7] = 8'h53;
    run_scan("entry7", 4'd5, 4'd3, w, 0, 1'b0);

    // Miss with empty slots
    w = '0;
    w[24] = 8'h9A;
    run_scan("miss", 4'd4, 4'd4, w, 0, 1'b0);

    // Ignored start and snapshot isolation
    w = '0;
    w[18] = 8'h66;
    run_scan("isolate", 4'd6, 4'd6, w, 3, 1'b1);

    // Duplicates
    w = '0;
    w[4]  = 8'h77;
    w[12] = 8'h77;
    run_scan("dup", 4'd7, 4'd7, w, 0, 1'b0);

    // Border query, entry 0 also matches
    w = '0;
    w[0] = 8'hF6;
    run_scan("border", 4'd15, 4'd6, w, 0, 1'b0);

    // Back-to-back: next start right after done
    w = '0;
    w[1] = 8'h21;
    run_scan("b2b", 4'd2, 4'd1, w, 0, 1'b0);

    for (int t = 0; t < 16; t++) begin
      rq_x = 4'($urandom_range(1, 14));
      rq_y = 4'($urandom_range(1, 14));
      for (int i = 0; i < NW; i++) begin
        w[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        w[$urandom_range(0, NW - 1)] = {rq_x, rq_y};
      end
      ifc.xmin = 4'($urandom_range(0, 3));
      ifc.xmax = 4'($urandom_range(12, 15));
      ifc.ymin = 4'($urandom_range(0, 3));
      ifc.ymax = 4'($urandom_range(12, 15));
      run_scan("rand", rq_x, rq_y, w, 0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wall_scan_reader.md
# wall_scan_reader

Sequential consumer of the packed wall list produced by the wall-spawn logic. On a `start` pulse it snapshots the query coordinate and the full `wall_locations` array, then walks the list one entry per clock. It reports whether the query coincides with a placed wall, and which entry matched. It sits between the wall generator and the snake next-move / apple-placement logic, replacing a wide single-cycle compare with a time-multiplexed one.

## Interface
Parameters:
- `NUM_WALLS`, 25: entries in the wall list.
- `IDX_W`, 5: width of `hit_index`; must satisfy 2^IDX_W > NUM_WALLS.

Ports:
- `system_clk`  in  1  system clock; all state on rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request pulse; sampled only in IDLE.
- `query_x`, `query_y`  in  4 each  coordinate to test.
- `wall_locations`  in  [NUM_WALLS-1:0][7:0]  packed entries {x[7:4], y[3:0]}.
- `xmax`, `xmin`, `ymax`, `ymin`  in  4 each  arena bounds; used only with the border macro.
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle.
- `done`  out  1  single-cycle result strobe.
- `hit`  out  1  query hits a wall (list entry, or border when enabled).
- `hit_border`  out  1  hit caused by the border check.
- `hit_index`  out  IDX_W  index of the matching entry; all-ones on a border hit or a miss.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE with `start`=1:
  - Latch `query_x`/`query_y`, all `NUM_WALLS` entries, and the four bounds.
  - Clear `hit`, `hit_border`; set `hit_index` to all-ones.
  - Set `idx`=0 and go to SCAN.
- SCAN:
  - Compare `snap[idx]` against {qx,qy}.
  - An entry equal to 8'h00 is empty and never matches; (0,0) is always border.
  - Match: `hit`=1, `hit_index`=idx, go to DONE.
  - No match with `idx`=NUM_WALLS-1: go to DONE with `hit`=0.
  - Otherwise `idx`+1.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- Result outputs (`hit`, `hit_border`, `hit_index`) hold until the next accepted `start`.
- Lowest index wins; duplicate entries cannot produce a later index.
- `start` while `busy`=1 is ignored. It is not queued.
- Changes to inputs after acceptance do not affect the scan in progress.
- `idx` never exceeds NUM_WALLS-1 and never wraps.

## Timing
- Reset (async, any state): state IDLE, `busy`=0, `done`=0, `hit`=0, `hit_border`=0, `hit_index`=all-ones, `idx`=0, snapshot cleared.
- `start` is sampled at edge E0, and `busy` rises after E0.
- Match at index k: `done` is high in the cycle after edge E0+k+1, so latency is k+2 cycles.
- Full miss: `done` follows edge E0+NUM_WALLS; latency 26 cycles at default.
- `busy` falls in the same edge that drops `done`.
- Earliest next accepted `start` is the cycle after `done`. Back-to-back throughput is one scan per latency+1 cycles.
- Reset during SCAN aborts the scan with no `done` pulse.

## Configuration
- `WALL_SCAN_BORDER_EN` defined:
  - In the first SCAN cycle (`idx`=0), evaluate qx>=xmax | qy>=ymax | qx<=xmin | qy<=ymin on the latched bounds.
  - If true: `hit`=1, `hit_border`=1, `hit_index`=all-ones, go to DONE. Latency is 2 cycles.
  - The border check takes priority over an entry-0 match.
- Macro undefined:
  - Bound inputs are unused and their flops are not instantiated.
  - `hit_border` is tied to 0; only list entries can hit.

## Test plan
- Reset mid-scan:
  - Start a scan with no match, assert `nrst`=0 at cycle 10.
  - Required: immediate IDLE, all outputs at reset values, no `done`.
  - After release, a new `start` is accepted normally.
- Entry hit:
  - Entry 7 = 8'h53, query (5,3).
  - Required: `done` 9 cycles after start, `hit`=1, `hit_index`=7, `hit_border`=0.
- Miss with empty slots:
  - All entries 8'h00 except entry 24 = 8'h9A; query (4,4).
  - Required: `done` at 26 cycles, `hit`=0, `hit_index`=5'h1F.
- Ignored start and snapshot isolation:
  - Pulse `start` again at cycle 3; change entry 10 during the scan.
  - Required: a single `done`, and the result reflects the snapshot taken at acceptance.
- Duplicates:
  - Entries 4 and 12 both 8'h77; query (7,7).
  - Required: `hit_index`=4, latency 6 cycles.
- Border (macro on):
  - Bounds xmin=0, xmax=15, ymin=0, ymax=15; query (15,6); entry 0 = 8'hF6.
  - Required: `done` at 2 cycles, `hit`=1, `hit_border`=1, `hit_index`=5'h1F.
  - Same stimulus with the macro off: `hit_index`=0, `hit_border`=0.
